// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: core-side request/response channel and
// the word-wide single-port data-memory channel.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface load_store_unit_mem_if #(
  parameter int DEPTH = 8
);
  logic [DEPTH-1:0] mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  modport master (
    output mem_addr, mem_we, mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_addr, mem_we, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store bridge onto a word-wide single-port data memory.
// Sub-word stores go through a read-modify-write sequence (MERGE then WRITE).
module load_store_unit #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  load_store_unit_if.slave      core_io,
  load_store_unit_mem_if.master mem_io
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  // Little-endian lane extraction with sign/zero extension.
  function automatic logic [WIDTH-1:0] load_format(input logic [WIDTH-1:0] word,
                                                   input logic [1:0]       size,
                                                   input logic [1:0]       lane,
                                                   input logic             uns);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old,
                                                   input logic [15:0]      wd,
                                                   input logic [1:0]       size,
                                                   input logic [1:0]       lane);
    logic [WIDTH-1:0] r;
    r = old;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]    = wd[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             accept_s, err_s, align_err_s, below_s, range_s;
  logic [29:0]      off_word_s;

  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic             uns_q, uns_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [DEPTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  assign accept_s   = core_io.req_valid && (state_q == ST_IDLE);
  assign off_word_s = core_io.req_addr[31:2] - BASE_WORD;
  assign below_s    = core_io.req_addr < BASE_ADDR;
  assign range_s    = |off_word_s[29:DEPTH];
  assign err_s      = align_err_s | below_s | range_s;

  // Size legality and natural-alignment check of the incoming request.
  always_comb begin
    case (core_io.req_size)
      SZ_BYTE: align_err_s = 1'b0;
      SZ_HALF: align_err_s = core_io.req_addr[0];
      SZ_WORD: align_err_s = |core_io.req_addr[1:0];
      default: align_err_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!core_io.req_valid) begin
          state_d = ST_IDLE;
        end else if (err_s) begin
          state_d = ST_RESP;
        end else if (!core_io.req_we) begin
          state_d = ST_LOAD;
        end else if (core_io.req_size == SZ_WORD) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_MERGE;
        end
      end
      ST_LOAD:  state_d = ST_RESP;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake/strobe outputs depend on the state register alone.
  always_comb begin
    core_io.req_ready = (state_q == ST_IDLE);
    mem_io.mem_we     = (state_q == ST_WRITE);
    core_io.rsp_valid = (state_q == ST_RESP);
  end

  // Request capture, load formatting and store merge.
  always_comb begin
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept_s) begin
      size_d      = core_io.req_size;
      lane_d      = core_io.req_addr[1:0];
      uns_d       = core_io.req_unsigned;
      wdata_d     = core_io.req_wdata[15:0];
      mem_addr_d  = off_word_s[DEPTH-1:0];
      mem_wd_d    = core_io.req_wdata;
      rsp_rdata_d = {WIDTH{1'b0}};
      rsp_err_d   = err_s;
    end else begin
      case (state_q)
        ST_LOAD:  rsp_rdata_d = load_format(mem_io.mem_rd, size_q, lane_q, uns_q);
        ST_MERGE: mem_wd_d    = store_merge(mem_io.mem_rd, wdata_q, size_q, lane_q);
        default:  rsp_rdata_d = rsp_rdata_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 16'h0000;
      mem_addr_q  <= {DEPTH{1'b0}};
      mem_wd_q    <= {WIDTH{1'b0}};
      rsp_rdata_q <= {WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_io.mem_addr   = mem_addr_q;
  assign mem_io.mem_wd     = mem_wd_q;
  assign core_io.rsp_rdata = rsp_rdata_q;
  assign core_io.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected responses checked
// at each rsp_valid pulse, plus direct checks of memory contents and reset.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  load_store_unit_if                     core_bus ();
  load_store_unit_mem_if #(.DEPTH(8))    mem_bus ();

  load_store_unit #(.WIDTH(32), .DEPTH(8), .BASE_ADDR(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .core_io (core_bus.slave),
    .mem_io  (mem_bus.master)
  );

  logic [31:0] tb_mem [256];
  assign mem_bus.mem_rd = tb_mem[mem_bus.mem_addr];
  always @(posedge clk) if (mem_bus.mem_we) tb_mem[mem_bus.mem_addr] = mem_bus.mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          we_cnt;
    int          we_off;
    logic [7:0]  maddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   acc_q[$];
  int   cur_acc = 0;
  int   we_cnt  = 0;
  int   we_cyc  = 0;
  int   bad     = 0;

  // Monitor: tracks accepts and write strobes, scores every response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_bus.req_valid && core_bus.req_ready) begin
        cur_acc = cyc;
        we_cnt  = 0;
        we_cyc  = 0;
        acc_q.push_back(cyc);
      end
      if (mem_bus.mem_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (core_bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, core_bus.rsp_valid}, 32'd0);
        end else begin
          cur_e = exp_q.pop_front();
          chk({cur_e.tag, "_err"},   {31'd0, core_bus.rsp_err}, {31'd0, cur_e.err});
          chk({cur_e.tag, "_rdata"}, core_bus.rsp_rdata, cur_e.rdata);
          chk({cur_e.tag, "_lat"},   32'(cyc - cur_acc), 32'(cur_e.lat));
          chk({cur_e.tag, "_wecnt"}, 32'(we_cnt), 32'(cur_e.we_cnt));
          if (cur_e.we_cnt != 0)
            chk({cur_e.tag, "_wecyc"}, 32'(we_cyc - cur_acc), 32'(cur_e.we_off));
          chk({cur_e.tag, "_maddr"}, {24'd0, mem_bus.mem_addr}, {24'd0, cur_e.maddr});
        end
      end
    end
  end

  function automatic exp_t mk_exp(input string tag, input logic [31:0] addr, input logic err,
                                  input logic [31:0] rdata, input int lat, input int wc, input int wo);
    exp_t e;
    e.tag    = tag;
    e.err    = err;
    e.rdata  = rdata;
    e.lat    = lat;
    e.we_cnt = wc;
    e.we_off = wo;
    e.maddr  = addr[9:2];
    return e;
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    core_bus.req_valid    = 1'b1;
    core_bus.req_we       = we;
    core_bus.req_addr     = addr;
    core_bus.req_size     = size;
    core_bus.req_unsigned = uns;
    core_bus.req_wdata    = wdata;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata, input int lat,
                        input int wc, input int wo);
    exp_q.push_back(mk_exp(tag, addr, err, rdata, lat, wc, wo));
    @(posedge clk); #1;
    drive(we, addr, size, uns, wdata);
    @(posedge clk); #1;
    core_bus.req_valid = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    reset_n               = 1'b0;
    core_bus.req_valid    = 1'b0;
    core_bus.req_we       = 1'b0;
    core_bus.req_addr     = 32'h0;
    core_bus.req_size     = 2'b00;
    core_bus.req_unsigned = 1'b0;
    core_bus.req_wdata    = 32'h0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[255] = 32'hCAFE_F00D;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",    {31'd0, core_bus.req_ready}, 32'd1);
    chk("rst_rspvalid", {31'd0, core_bus.rsp_valid}, 32'd0);
    chk("rst_rdata",    core_bus.rsp_rdata, 32'd0);
    chk("rst_err",      {31'd0, core_bus.rsp_err}, 32'd0);
    chk("rst_we",       {31'd0, mem_bus.mem_we}, 32'd0);
    chk("rst_maddr",    {24'd0, mem_bus.mem_addr}, 32'd0);
    chk("rst_wd",       mem_bus.mem_wd, 32'd0);
    reset_n = 1'b1;

    // word store/load
    do_req("sw10",  1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 1);
    chk("mem_sw10", tb_mem[4], 32'hDEAD_BEEF);
    do_req("lw10",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 0);

    // byte store and signed/unsigned byte loads
    do_req("sb11",  1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 32'h0, 3, 1, 2);
    chk("mem_sb11", tb_mem[4], 32'hDEAD_80EF);
    do_req("lb11",  1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 0);
    do_req("lbu11", 1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 0);

    // half store and half/byte loads on every lane
    do_req("sh12",  1'b1, 32'h12, 2'b01, 1'b0, 32'hABCD_1234, 1'b0, 32'h0, 3, 1, 2);
    chk("mem_sh12", tb_mem[4], 32'h1234_80EF);
    do_req("lh12",  1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0000_1234, 2, 0, 0);
    do_req("lh10",  1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFF_80EF, 2, 0, 0);
    do_req("lhu10", 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 1'b0, 32'h0000_80EF, 2, 0, 0);
    do_req("lb13",  1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0000_0012, 2, 0, 0);
    do_req("lb10",  1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFEF, 2, 0, 0);

    // misalignment / illegal size
    do_req("lw13e", 1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("sh11e", 1'b1, 32'h11, 2'b01, 1'b0, 32'h5555_5555, 1'b1, 32'h0, 1, 0, 0);
    do_req("sz3e",  1'b1, 32'h10, 2'b11, 1'b0, 32'h7777_7777, 1'b1, 32'h0, 1, 0, 0);
    chk("mem_err_untouched", tb_mem[4], 32'h1234_80EF);

    // range boundaries
    do_req("lw3fc", 1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 0);
    do_req("lw400", 1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("sw400", 1'b1, 32'h400, 2'b10, 1'b0, 32'h1111_1111, 1'b1, 32'h0, 1, 0, 0);
    chk("mem_w0_untouched", tb_mem[0], 32'h0);

    // back-to-back with req_valid held high
    acc_q.delete();
    exp_q.push_back(mk_exp("b2b0", 32'h3FC, 1'b0, 32'hCAFE_F00D, 2, 0, 0));
    exp_q.push_back(mk_exp("b2b1", 32'h3FC, 1'b0, 32'hCAFE_F00D, 2, 0, 0));
    exp_q.push_back(mk_exp("b2b2", 32'h3FC, 1'b0, 32'hCAFE_F00D, 2, 0, 0));
    @(posedge clk); #1;
    drive(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    core_bus.req_valid = 1'b0;
    wait_done("b2b");
    chk("b2b_accepts", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 3) begin
      chk("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd3);
      chk("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd3);
    end

    // reset during MERGE of a byte store
    @(posedge clk); #1;
    drive(1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_0055);
    @(posedge clk); #1;
    core_bus.req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstm_we",    {31'd0, mem_bus.mem_we}, 32'd0);
    chk("rstm_rsp",   {31'd0, core_bus.rsp_valid}, 32'd0);
    chk("rstm_ready", {31'd0, core_bus.req_ready}, 32'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_bus.mem_we || core_bus.rsp_valid) bad++;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_bus.mem_we || core_bus.rsp_valid) bad++;
    end
    chk("rstm_quiet",     32'(bad), 32'd0);
    chk("rstm_mem",       tb_mem[4], 32'h1234_80EF);
    chk("rstm_ready_rel", {31'd0, core_bus.req_ready}, 32'd1);
    do_req("lw_after_rst", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1234_80EF, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
